rr_mux_stream: RTL and testbench
================================

Name: rr_mux_stream

Overview:
- Parametrised, registered N:1 stream multiplexer. Next generation of the 4:1 case-based data mux.
- Merges N_CH valid/ready input channels of WIDTH bits into one output stream.
- Arbitration is selectable at run time: round-robin or fixed priority.
- Sits between producer channels and a single shared consumer. Registered output stage gives 1-cycle latency and full throughput.

Parameters:
- N_CH, 4, number of input channels (≥2).
- WIDTH, 4, data width per channel in bits.
- CH_W, $clog2(N_CH), derived localparam; width of channel index. Not overridable.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready; one-hot or zero.
- in_data  input  N_CH*WIDTH  packed channel data; channel i at bits [i*WIDTH +: WIDTH].
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  WIDTH  registered data.
- out_ch  output  CH_W  index of the channel out_data came from.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - out_valid=0, out_data=0, out_ch=0.
  - RR pointer last=N_CH-1, so channel 0 has top priority after reset.
  - Reset overrides any transfer in the same cycle. Mid-stream reset drops the held word without it being transferred.
- Transfer rules:
  - Input transfer on channel i: in_valid[i] && in_ready[i] at a clk edge.
  - Output transfer: out_valid && out_ready.
- Load condition: load = (!out_valid || out_ready) && |in_valid.
- Grant (combinational, one-hot):
  - mode=0: first valid channel searching last+1, last+2, … with wrap modulo N_CH.
  - mode=1: lowest-index valid channel.
  - No valid input: grant = 0.
- in_ready = grant when (!out_valid || out_ready), else 0.
  - in_ready may depend on in_valid and out_ready.
  - in_valid must not depend on in_ready. Producers hold data stable while valid && !ready.
- On load, at the next edge:
  - out_data = granted channel data, out_ch = its index, out_valid=1.
  - last = granted index, updated in both modes.
- Output drained with no load (output transfer, no valid input): out_valid=0; out_data and out_ch keep their last value.
- Backpressure: out_valid && !out_ready → out_valid, out_data, out_ch held; all in_ready=0; last unchanged.
- Latency: input transfer at edge k → word on out_data from edge k until its output transfer.
- Throughput: one word per cycle while out_ready=1. Simultaneous output transfer and new load in the same cycle is allowed, with no bubble.
- Fairness: in mode=0 with all channels valid continuously, grants cycle 0,1,…,N_CH-1,0,…
- A mode change takes effect on the next grant computation. There is no pipeline flush and last is preserved.
- Single valid channel: always granted, in either mode.
- Non-power-of-2 N_CH (e.g. 3): the pointer wraps from N_CH-1 to 0. Index values ≥N_CH never appear on out_ch.

Test Plan:
- Reset, then hold rst_n=0 with in_valid=4'b1111 → out_valid=0, in_ready=0, out_data=0, out_ch=0 on every cycle.
- mode=0, in_valid=4'b1111, data d_i=4'hA+i, out_ready=1 for 8 cycles → out_ch sequence 0,1,2,3,0,1,2,3; out_data A,B,C,D,A,B,C,D; out_valid=1 continuously.
- mode=1, same stimulus → out_ch=0 every cycle, only in_ready[0] ever asserted. Then drop in_valid[0] → next word out_ch=1.
- Backpressure: mode=0, channels 1 and 3 valid, out_ready=0 for 3 cycles after the first load → out_data/out_ch frozen at ch1, in_ready=0. Release out_ready → next word ch3, then ch1.
- Mode switch mid-stream: mode=0 after grants 0,1; switch to mode=1 with all valid → next grant ch0. Switch back to mode=0 → next grant ch1 (last=0).
- N_CH=3, WIDTH=8, all valid, out_ready=1; assert rst_n=0 for one cycle while out_valid=1 → out_valid=0 the next cycle. The sequence then restarts at ch0, and out_ch only takes values 0,1,2.

Source files
------------

// File: rtl/rr_mux_stream.sv
// Registered N:1 valid/ready stream mux, run-time selectable round-robin or fixed-priority arbitration.
// One-cycle latency, full throughput; with out_valid && !out_ready the output word is held and every in_ready drops.
module rr_mux_stream #(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 4,
    localparam int CH_W  = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [CH_W-1:0]       out_ch
);

    logic [CH_W-1:0]  last;
    logic [N_CH-1:0]  grant;
    logic [CH_W-1:0]  grant_idx;
    logic             found;
    logic             accept;
    logic             load;
    logic [WIDTH-1:0] sel_data;

    assign accept = !out_valid || out_ready;
    assign load   = accept && (|in_valid);

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        if (mode) begin
            for (int i = 0; i < N_CH; i++) begin
                if (!found && in_valid[i]) begin
                    found     = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = CH_W'(i);
                end
            end
        end else begin
            // Search starts one past the last winner and wraps explicitly so non-power-of-2 N_CH never yields an index >= N_CH.
            for (int k = 1; k <= N_CH; k++) begin
                idx = int'(last) + k;
                if (idx >= N_CH) idx = idx - N_CH;
                if (!found && in_valid[idx]) begin
                    found       = 1'b1;
                    grant[idx]  = 1'b1;
                    grant_idx   = CH_W'(idx);
                end
            end
        end
    end

    assign sel_data = in_data[grant_idx*WIDTH +: WIDTH];

    // Reset blocks any handshake so no producer believes a word was taken during reset.
    assign in_ready = (rst_n && accept) ? grant : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            last      <= CH_W'(N_CH - 1);
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_ch    <= grant_idx;
            last      <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_stream.sv
// Directed bench for rr_mux_stream: a 4-channel vector table plus a 3-channel sequence with mid-stream reset.
module tb_rr_mux_stream;

    logic        clk;
    logic        rst_n, mode, out_ready;
    logic [3:0]  in_valid, in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [1:0]  out_ch;

    logic        rst3_n, mode3, out_ready3;
    logic [2:0]  in_valid3, in_ready3;
    logic [23:0] in_data3;
    logic        out_valid3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;

    int n_cmp = 0;
    int n_err = 0;

    rr_mux_stream #(.N_CH(4), .WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch)
    );

    rr_mux_stream #(.N_CH(3), .WIDTH(8)) dut3 (
        .clk(clk), .rst_n(rst3_n), .mode(mode3),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .out_data(out_data3), .out_ch(out_ch3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       mode;
        logic [3:0] iv;
        logic       ordy;
        logic [3:0] rdy;
        logic       ov;
        logic [3:0] od;
        logic [1:0] och;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r, input logic m, input logic [3:0] iv, input logic ordy,
                       input logic [3:0] rdy, input logic ov, input logic [3:0] od, input logic [1:0] och);
        vec_t v;
        v.rst_n = r; v.mode = m; v.iv = iv; v.ordy = ordy;
        v.rdy = rdy; v.ov = ov; v.od = od; v.och = och;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [1:0] ech;
        logic [7:0] edat;

        rst_n = 1'b0; mode = 1'b0; in_valid = '0; out_ready = 1'b1;
        in_data = 16'hDCBA;
        rst3_n = 1'b0; mode3 = 1'b0; in_valid3 = '0; out_ready3 = 1'b1;
        in_data3 = 24'h322110;

        // rst, mode, in_valid, out_ready | in_ready, out_valid, out_data, out_ch (after edge)
        add(0, 0, 4'b1111, 1, 4'b0000, 0, 4'h0, 2'd0);
        add(0, 0, 4'b1111, 1, 4'b0000, 0, 4'h0, 2'd0);
        for (int i = 0; i < 8; i++)
            add(1, 0, 4'b1111, 1, 4'(1 << (i % 4)), 1, 4'(4'hA + (i % 4)), 2'(i % 4));
        for (int i = 0; i < 3; i++)
            add(1, 1, 4'b1111, 1, 4'b0001, 1, 4'hA, 2'd0);
        add(1, 1, 4'b1110, 1, 4'b0010, 1, 4'hB, 2'd1);
        add(1, 1, 4'b0001, 1, 4'b0001, 1, 4'hA, 2'd0);
        add(1, 0, 4'b0000, 1, 4'b0000, 0, 4'hA, 2'd0);
        add(1, 0, 4'b1010, 1, 4'b0010, 1, 4'hB, 2'd1);
        for (int i = 0; i < 3; i++)
            add(1, 0, 4'b1010, 0, 4'b0000, 1, 4'hB, 2'd1);
        add(1, 0, 4'b1010, 1, 4'b1000, 1, 4'hD, 2'd3);
        add(1, 0, 4'b1010, 1, 4'b0010, 1, 4'hB, 2'd1);
        add(1, 0, 4'b1001, 1, 4'b1000, 1, 4'hD, 2'd3);
        add(1, 0, 4'b1111, 1, 4'b0001, 1, 4'hA, 2'd0);
        add(1, 0, 4'b1111, 1, 4'b0010, 1, 4'hB, 2'd1);
        add(1, 1, 4'b1111, 1, 4'b0001, 1, 4'hA, 2'd0);
        add(1, 0, 4'b1111, 1, 4'b0010, 1, 4'hB, 2'd1);
        add(1, 0, 4'b0100, 1, 4'b0100, 1, 4'hC, 2'd2);
        add(1, 0, 4'b0100, 1, 4'b0100, 1, 4'hC, 2'd2);
        add(1, 0, 4'b1111, 0, 4'b0000, 1, 4'hC, 2'd2);
        add(0, 0, 4'b1111, 0, 4'b0000, 0, 4'h0, 2'd0);
        add(1, 0, 4'b1111, 1, 4'b0001, 1, 4'hA, 2'd0);

        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vt.size(); i++) begin
            rst_n = vt[i].rst_n; mode = vt[i].mode;
            in_valid = vt[i].iv; out_ready = vt[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vt[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vt[i].ov));
            chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vt[i].od));
            chk($sformatf("v%0d_out_ch", i), 32'(out_ch), 32'(vt[i].och));
        end

        // Three-channel instance: wrap 2 -> 0 and reset while a word is held.
        in_valid3 = 3'b111;
        @(posedge clk);
        #1;
        chk("n3_reset_valid", 32'(out_valid3), 32'd0);
        rst3_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ech = 2'(k % 3);
            edat = 8'h10 + 8'(k % 3) * 8'h11;
            #1;
            chk($sformatf("n3_a%0d_in_ready", k), 32'(in_ready3), 32'(1 << ech));
            @(posedge clk);
            #1;
            chk($sformatf("n3_a%0d_out_valid", k), 32'(out_valid3), 32'd1);
            chk($sformatf("n3_a%0d_out_ch", k), 32'(out_ch3), 32'(ech));
            chk($sformatf("n3_a%0d_out_data", k), 32'(out_data3), 32'(edat));
        end
        rst3_n = 1'b0;
        #1;
        chk("n3_rst_in_ready", 32'(in_ready3), 32'd0);
        @(posedge clk);
        #1;
        chk("n3_rst_out_valid", 32'(out_valid3), 32'd0);
        chk("n3_rst_out_data", 32'(out_data3), 32'd0);
        chk("n3_rst_out_ch", 32'(out_ch3), 32'd0);
        rst3_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            ech = 2'(k % 3);
            edat = 8'h10 + 8'(k % 3) * 8'h11;
            #1;
            chk($sformatf("n3_b%0d_in_ready", k), 32'(in_ready3), 32'(1 << ech));
            @(posedge clk);
            #1;
            chk($sformatf("n3_b%0d_out_valid", k), 32'(out_valid3), 32'd1);
            chk($sformatf("n3_b%0d_out_ch", k), 32'(out_ch3), 32'(ech));
            chk($sformatf("n3_b%0d_out_data", k), 32'(out_data3), 32'(edat));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
